// File: rtl/imem_boot_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// The loader is the slave of the byte stream and drives the write port;
// the master side feeds bytes and observes the writes.
interface imem_boot_loader_if #(
  parameter int ADDR_WIDTH = 12
);
  logic [7:0]            in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;

  modport slave (
    input  in_data, in_valid,
    output in_ready, imem_we, imem_addr, imem_wdata
  );

  modport master (
    output in_data, in_valid,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_boot_loader.sv
// Byte-serial image loader: header N, N big-endian words, XOR checksum byte.
// One write per word, issued the cycle after its 4th byte; 1 byte/cycle sustained.
// in_ready drops outside the load states; the CPU is held in reset until RUN.
module imem_boot_loader #(
  parameter int ADDR_WIDTH = 12,
  parameter int IMEM_DEPTH = 4096,
  parameter int RST_HOLD   = 4
) (
  input  logic               clk,
  input  logic               rst,
  imem_boot_loader_if.slave  bus,
  input  logic               reload,
  output logic               cpu_rst,
  output logic               boot_done,
  output logic               boot_err
);

  localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

  typedef enum logic [2:0] {
    S_HDR_HI,
    S_HDR_LO,
    S_DATA,
    S_CSUM,
    S_HOLD,
    S_RUN,
    S_ERROR
  } state_t;

  state_t                state_q, state_d;
  logic [15:0]           n_q, n_d;
  logic [23:0]           shift_q, shift_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [15:0]           word_idx_q, word_idx_d;
  logic [7:0]            xor_q, xor_d;
  logic [HOLD_W-1:0]     hold_cnt_q, hold_cnt_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  cpu_rst_q, cpu_rst_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic                  accept;
  logic [15:0]           n_full;

  // The reset cycle itself must not accept a byte, hence the rst term.
  assign bus.in_ready = !rst && (state_q inside {S_HDR_HI, S_HDR_LO, S_DATA, S_CSUM});
  assign accept       = bus.in_valid && bus.in_ready;
  assign n_full       = {n_q[15:8], bus.in_data};

  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign cpu_rst        = cpu_rst_q;
  assign boot_done      = done_q;
  assign boot_err       = err_q;

  // Next-state and output decode; status flags are derived from the next state
  // so cpu_rst falls on the same edge that boot_done rises.
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    shift_d    = shift_q;
    byte_cnt_d = byte_cnt_q;
    word_idx_d = word_idx_q;
    xor_d      = xor_q;
    hold_cnt_d = hold_cnt_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;

    case (state_q)
      S_HDR_HI: begin
        if (accept) begin
          n_d[15:8] = bus.in_data;
          state_d   = S_HDR_LO;
        end
      end
      S_HDR_LO: begin
        if (accept) begin
          n_d[7:0] = bus.in_data;
          // Unsigned, full-width compare so e.g. 0xFFFF is never truncated.
          if (n_full == 16'd0 || {1'b0, n_full} > 17'(IMEM_DEPTH)) state_d = S_ERROR;
          else                                                      state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          xor_d = xor_q ^ bus.in_data;
          if (byte_cnt_q == 2'd3) begin
            we_d       = 1'b1;
            addr_d     = word_idx_q[ADDR_WIDTH-1:0];
            wdata_d    = {shift_q, bus.in_data};
            byte_cnt_d = 2'd0;
            word_idx_d = word_idx_q + 16'd1;
            if (word_idx_q == n_q - 16'd1) state_d = S_CSUM;
          end else begin
            shift_d    = {shift_q[15:0], bus.in_data};
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end
      end
      S_CSUM: begin
        if (accept) begin
          hold_cnt_d = '0;
          state_d    = (bus.in_data == xor_q) ? S_HOLD : S_ERROR;
        end
      end
      S_HOLD: begin
        if (hold_cnt_q == HOLD_W'(RST_HOLD - 1)) state_d = S_RUN;
        else                                     hold_cnt_d = hold_cnt_q + 1'b1;
      end
      S_RUN, S_ERROR: begin
        if (reload) begin
          state_d    = S_HDR_HI;
          byte_cnt_d = 2'd0;
          word_idx_d = 16'd0;
          xor_d      = 8'd0;
          hold_cnt_d = '0;
        end
      end
      default: state_d = S_HDR_HI;
    endcase

    cpu_rst_d = (state_d != S_RUN);
    done_d    = (state_d == S_RUN);
    err_d     = (state_d == S_ERROR);
  end

  // State and datapath registers; rst aborts any load in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_HDR_HI;
      n_q        <= 16'd0;
      shift_q    <= 24'd0;
      byte_cnt_q <= 2'd0;
      word_idx_q <= 16'd0;
      xor_q      <= 8'd0;
      hold_cnt_q <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 32'd0;
      cpu_rst_q  <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      shift_q    <= shift_d;
      byte_cnt_q <= byte_cnt_d;
      word_idx_q <= word_idx_d;
      xor_q      <= xor_d;
      hold_cnt_q <= hold_cnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cpu_rst_q  <= cpu_rst_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

endmodule
